serial_deserializer: RTL

//  Receive end of the lab serial link: rebuilds words sent LSB-first by the 8-bit shift register in rotate-right mode.

---
 rtl/serial_deserializer_if.sv | 22 ++
 rtl/serial_deserializer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/serial_deserializer_if.sv
// Signal bundle between the serial line and the word-level consumer of serial_deserializer.
// data_valid is a single-cycle strobe: Data_OUT is captured that cycle, there is no ready/backpressure.
interface serial_deserializer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  serial_in;
   logic [DATA_WIDTH-1:0] Data_OUT;
   logic                  data_valid;
   logic                  framing_error;
   logic                  busy;
   logic [2:0]            state_dbg;

   modport master (
      output serial_in,
      input  Data_OUT, data_valid, framing_error, busy, state_dbg
   );

   modport slave (
      input  serial_in,
      output Data_OUT, data_valid, framing_error, busy, state_dbg
   );
endinterface

// File: rtl/serial_deserializer.sv
// Receiver for start/data(LSB first)/stop frames: centre-samples each bit with a cycle counter
// and presents the assembled word with a one-cycle valid strobe, or flags a bad stop bit.
module serial_deserializer #(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input logic              clock,
   input logic              reset,
   serial_deserializer_if.slave bus
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      STOP    = 3'd3,
      RECOVER = 3'd4
   } state_t;

   state_t                state, state_n;
   logic                  rx_meta, rx_s;
   logic [CW-1:0]         bit_cnt, bit_cnt_n;
   logic [IW-1:0]         bit_idx, bit_idx_n;
   logic [DATA_WIDTH-1:0] shift, shift_n;
   logic [DATA_WIDTH-1:0] data_q, data_n;
   logic                  valid_q, valid_n;
   logic                  ferr_q, ferr_n;

   // Two-flop synchronizer; resets to the idle line level so no false start follows reset.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= bus.serial_in;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shift   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         bit_idx <= bit_idx_n;
         shift   <= shift_n;
         data_q  <= data_n;
         valid_q <= valid_n;
         ferr_q  <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      data_n    = data_q;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
      case (state)
         IDLE: begin
            bit_cnt_n = '0;
            if (!rx_s) state_n = START;
         end
         START: begin
            // Half a bit in: confirm the start bit, else treat it as a glitch.
            if (bit_cnt == CNT_HALF) begin
               bit_cnt_n = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         DATA: begin
            if (bit_cnt == CNT_LAST) begin
               bit_cnt_n = '0;
               shift_n   = {rx_s, shift[DATA_WIDTH-1:1]};
               if (bit_idx == IDX_LAST) state_n = STOP;
               else bit_idx_n = bit_idx + 1'b1;
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         STOP: begin
            if (bit_cnt == CNT_LAST) begin
               bit_cnt_n = '0;
               if (rx_s) begin
                  data_n  = shift;
                  valid_n = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = RECOVER;
               end
            end else begin
               bit_cnt_n = bit_cnt + 1'b1;
            end
         end
         RECOVER: begin
            bit_cnt_n = '0;
            if (rx_s) state_n = IDLE;
         end
         default: begin
            state_n   = IDLE;
            bit_cnt_n = '0;
         end
      endcase
   end

   assign bus.Data_OUT      = data_q;
   assign bus.data_valid    = valid_q;
   assign bus.framing_error = ferr_q;
   assign bus.busy          = (state != IDLE);
   assign bus.state_dbg     = state;
endmodule
